// File: rtl/styler_scan_sequencer_if.sv
// -----------------------------------------------------------------------------
// styler_scan_sequencer_if
//
// Bus bundle between the scan sequencer and its two neighbours:
//   * fetch port : req_valid/req_ready handshake carrying the cell address
//                  (req_col, req_row). The answer comes back later as a
//                  single-cycle rsp_valid pulse with rsp_bitmap/rsp_attr.
//   * styler port: cell_valid/cell_ready handshake carrying the scanline,
//                  glyph bitmap row, attribute word and cursor flag of the
//                  cell currently on offer.
//
// Modports:
//   master - the sequencer (drives requests and styler inputs)
//   slave  - the environment (fetch memory plus the downstream styler)
// -----------------------------------------------------------------------------
interface styler_scan_sequencer_if;

  // Fetch request / response
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_col;
  logic [4:0]  req_row;
  logic        rsp_valid;
  logic [15:0] rsp_bitmap;
  logic [24:0] rsp_attr;

  // Styler presentation
  logic        cell_valid;
  logic        cell_ready;
  logic [3:0]  sty_scanline;
  logic [15:0] sty_bitmap;
  logic [24:0] sty_attr;
  logic        cursor_hit;

  modport master (
    output req_valid,
    output req_col,
    output req_row,
    input  req_ready,
    input  rsp_valid,
    input  rsp_bitmap,
    input  rsp_attr,
    output cell_valid,
    output sty_scanline,
    output sty_bitmap,
    output sty_attr,
    output cursor_hit,
    input  cell_ready
  );

  modport slave (
    input  req_valid,
    input  req_col,
    input  req_row,
    output req_ready,
    output rsp_valid,
    output rsp_bitmap,
    output rsp_attr,
    input  cell_valid,
    input  sty_scanline,
    input  sty_bitmap,
    input  sty_attr,
    input  cursor_hit,
    output cell_ready
  );

endinterface

// File: rtl/styler_scan_sequencer.sv
// -----------------------------------------------------------------------------
// styler_scan_sequencer
//
// Walks a text frame one character cell at a time, column fastest, then
// scanline, then row. For every (col, scan, row) step it fetches the glyph
// bitmap row and attribute word of cell (col, row), then offers them to the
// character styler together with the scanline number and a cursor flag.
// It also derives the faint and blink phase clocks from frame counts; both
// phases change only at frame boundaries.
//
// Parameters:
//   COLS         text columns per row        (2..128)
//   ROWS         text rows per frame         (2..32)
//   SCANLINES    scanlines per cell          (2..16)
//   BLINK_FRAMES frames per blink_phase flip (1..255)
//
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset
//   start        begin a frame (only looked at while idle)
//   continuous   chain straight into the next frame at frame end
//   bus          fetch + styler handshakes (styler_scan_sequencer_if.master)
//   cursor_col   cursor column
//   cursor_row   cursor row
//   faint_phase  toggles once per frame
//   blink_phase  toggles once every BLINK_FRAMES frames
//   busy         frame in progress
//   frame_done   one-cycle pulse after the last cell of a frame is consumed
//
// Build option:
//   STYLER_SEQ_CURSOR_EN  when defined, cursor_hit flags the cell at
//                         (cursor_col, cursor_row) on every scanline; when
//                         undefined the compare is absent, cursor_hit stays 0
//                         and the cursor inputs are unused.
// -----------------------------------------------------------------------------
module styler_scan_sequencer #(
  parameter int COLS         = 80,
  parameter int ROWS         = 25,
  parameter int SCANLINES    = 16,
  parameter int BLINK_FRAMES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  styler_scan_sequencer_if.master bus,
  input  logic [6:0] cursor_col,
  input  logic [4:0] cursor_row,
  output logic       faint_phase,
  output logic       blink_phase,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [6:0] COL_LAST   = 7'(COLS - 1);
  localparam logic [3:0] SCAN_LAST  = 4'(SCANLINES - 1);
  localparam logic [4:0] ROW_LAST   = 5'(ROWS - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_PRESENT
  } state_t;

  state_t      state;

  // Frame position of the cell currently being fetched / presented.
  logic [6:0]  col;
  logic [3:0]  scan;
  logic [4:0]  row;

  // Frames seen since the last blink_phase flip.
  logic [7:0]  blink_cnt;

  // Registered outputs.
  logic        req_valid_q;
  logic        cell_valid_q;
  logic [3:0]  sty_scanline_q;
  logic [15:0] sty_bitmap_q;
  logic [24:0] sty_attr_q;
  logic        cursor_hit_q;
  logic        faint_q;
  logic        blink_q;
  logic        busy_q;
  logic        frame_done_q;

  // Next-position decode.
  logic        col_wrap;
  logic        scan_wrap;
  logic        last_cell;
  logic [6:0]  col_nxt;
  logic [3:0]  scan_nxt;
  logic [4:0]  row_nxt;
  logic        cursor_match;

  // NOTE: every signal driven here gets a default before any branch, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    col_wrap  = 1'b0;
    scan_wrap = 1'b0;
    last_cell = 1'b0;
    col_nxt   = col;
    scan_nxt  = scan;
    row_nxt   = row;

    col_wrap  = (col == COL_LAST);
    scan_wrap = (scan == SCAN_LAST);
    last_cell = col_wrap && scan_wrap && (row == ROW_LAST);

    if (col_wrap) begin
      col_nxt = '0;
      if (scan_wrap) begin
        scan_nxt = '0;
        // Row overflow only happens on the last cell, which clears the
        // counters on its own path, so no wrap is needed here.
        row_nxt  = row + 5'd1;
      end else begin
        scan_nxt = scan + 4'd1;
      end
    end else begin
      col_nxt = col + 7'd1;
    end
  end

`ifdef STYLER_SEQ_CURSOR_EN
  always_comb begin
    cursor_match = (col == cursor_col) && (row == cursor_row);
  end
`else
  always_comb begin
    cursor_match = 1'b0;
  end

  // Cursor position is irrelevant in this build; fold it into a sink so the
  // inputs stay on the port list without dangling.
  logic unused_cursor;
  assign unused_cursor = ^{cursor_col, cursor_row};
`endif

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours, independent of
  // statement order in the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      col            <= '0;
      scan           <= '0;
      row            <= '0;
      blink_cnt      <= '0;
      req_valid_q    <= 1'b0;
      cell_valid_q   <= 1'b0;
      // NOTE: the styler datapath registers are reset as well, not only the
      // control bits, because every output must read zero after reset.
      sty_scanline_q <= '0;
      sty_bitmap_q   <= '0;
      sty_attr_q     <= '0;
      cursor_hit_q   <= 1'b0;
      faint_q        <= 1'b0;
      blink_q        <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            col         <= '0;
            scan        <= '0;
            row         <= '0;
            req_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state       <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          // Address (col,row) is held by the counters until accepted.
          if (req_valid_q && bus.req_ready) begin
            req_valid_q <= 1'b0;
            state       <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          // Only a response arriving here is taken; a pulse coincident with
          // the request handshake is seen while still in ST_FETCH and dropped.
          if (bus.rsp_valid) begin
            sty_bitmap_q   <= bus.rsp_bitmap;
            sty_attr_q     <= bus.rsp_attr;
            sty_scanline_q <= scan;
            cursor_hit_q   <= cursor_match;
            cell_valid_q   <= 1'b1;
            state          <= ST_PRESENT;
          end
        end

        ST_PRESENT: begin
          if (cell_valid_q && bus.cell_ready) begin
            cell_valid_q <= 1'b0;
            if (last_cell) begin
              frame_done_q <= 1'b1;
              faint_q      <= ~faint_q;
              if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_q   <= ~blink_q;
              end else begin
                blink_cnt <= blink_cnt + 8'd1;
              end
              col  <= '0;
              scan <= '0;
              row  <= '0;
              if (continuous) begin
                req_valid_q <= 1'b1;
                state       <= ST_FETCH;
              end else begin
                busy_q <= 1'b0;
                state  <= ST_IDLE;
              end
            end else begin
              col         <= col_nxt;
              scan        <= scan_nxt;
              row         <= row_nxt;
              req_valid_q <= 1'b1;
              state       <= ST_FETCH;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_valid    = req_valid_q;
  assign bus.req_col      = col;
  assign bus.req_row      = row;
  assign bus.cell_valid   = cell_valid_q;
  assign bus.sty_scanline = sty_scanline_q;
  assign bus.sty_bitmap   = sty_bitmap_q;
  assign bus.sty_attr     = sty_attr_q;
  assign bus.cursor_hit   = cursor_hit_q;

  assign faint_phase = faint_q;
  assign blink_phase = blink_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_styler_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_styler_scan_sequencer
//
// Scoreboard bench for styler_scan_sequencer on a 2x2 frame with 2 scanlines
// and BLINK_FRAMES=2. Stimulus pushes the expected requests, cells and
// frame-end phase values into queues; independent monitors pop and compare
// whenever the DUT completes a request handshake, a cell handshake or pulses
// frame_done. A fetch responder answers each accepted request one cycle later
// with data keyed on a response sequence number.
// -----------------------------------------------------------------------------
module tb_styler_scan_sequencer;

  localparam int COLS  = 2;
  localparam int ROWS  = 2;
  localparam int SCANS = 2;
  localparam int BLINK = 2;

  localparam logic [15:0] OV_BM = 16'hA5C3;
  localparam logic [24:0] OV_AT = 25'h1ABCDEF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic [6:0] cursor_col = 7'd1;
  logic [4:0] cursor_row = 5'd0;
  logic       faint_phase;
  logic       blink_phase;
  logic       busy;
  logic       frame_done;

  styler_scan_sequencer_if bus ();

  styler_scan_sequencer #(
    .COLS        (COLS),
    .ROWS        (ROWS),
    .SCANLINES   (SCANS),
    .BLINK_FRAMES(BLINK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .continuous (continuous),
    .bus        (bus),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .faint_phase(faint_phase),
    .blink_phase(blink_phase),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] col;
    logic [4:0] row;
  } req_t;

  typedef struct packed {
    logic [3:0]  scan;
    logic [15:0] bm;
    logic [24:0] at;
    logic        hit;
  } cell_t;

  typedef struct packed {
    logic faint;
    logic blink;
    logic busy;
  } frame_t;

  req_t   req_q[$];
  cell_t  cell_q[$];
  frame_t frame_q[$];

  int n_checks = 0;
  int n_pass = 0;
  int frames_seen = 0;
  int cells_seen = 0;

  // Responder controls (written by stimulus, read by responder).
  logic drop_rsp = 1'b0;
  logic spurious_en = 1'b0;
  logic ready_toggle = 1'b0;
  int   override_seq = -1;
  int   model_seq = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] bm_of(input int s);
    return {8'(s), 8'h5A};
  endfunction

  function automatic logic [24:0] at_of(input int s);
    return {8'(s) ^ 8'hC3, 17'h0ACE5};
  endfunction

  function automatic logic exp_hit(input int c, input int r);
`ifdef STYLER_SEQ_CURSOR_EN
    return (c == 1) && (r == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] all_outputs();
    return {bus.req_valid, bus.req_col, bus.req_row, bus.cell_valid,
            bus.sty_scanline, bus.sty_bitmap, bus.sty_attr, bus.cursor_hit,
            faint_phase, blink_phase, busy, frame_done};
  endfunction

  // Queue one full frame of expectations: col fastest, then scanline, then row.
  task automatic push_frame(input logic f, input logic b, input logic bz);
    req_t   rq;
    cell_t  ce;
    frame_t fr;
    for (int r = 0; r < ROWS; r++)
      for (int s = 0; s < SCANS; s++)
        for (int c = 0; c < COLS; c++) begin
          rq.col = 7'(c);
          rq.row = 5'(r);
          req_q.push_back(rq);
          ce.scan = 4'(s);
          ce.bm   = (model_seq == override_seq) ? OV_BM : bm_of(model_seq);
          ce.at   = (model_seq == override_seq) ? OV_AT : at_of(model_seq);
          ce.hit  = exp_hit(c, r);
          cell_q.push_back(ce);
          model_seq++;
        end
    fr.faint = f;
    fr.blink = b;
    fr.busy  = bz;
    frame_q.push_back(fr);
  endtask

  // Fetch responder: sole driver of req_ready and the rsp_* signals.
  initial begin
    logic pending;
    int   rsp_seq;
    pending = 1'b0;
    rsp_seq = 0;
    bus.req_ready  = 1'b1;
    bus.rsp_valid  = 1'b0;
    bus.rsp_bitmap = '0;
    bus.rsp_attr   = '0;
    forever begin
      @(negedge clk);
      bus.rsp_valid = 1'b0;
      if (!rst_n) begin
        pending = 1'b0;
        rsp_seq = 0;
        bus.req_ready = 1'b1;
      end else begin
        bus.req_ready = ready_toggle ? ~bus.req_ready : 1'b1;
        if (pending) begin
          bus.rsp_valid  = 1'b1;
          bus.rsp_bitmap = (rsp_seq == override_seq) ? OV_BM : bm_of(rsp_seq);
          bus.rsp_attr   = (rsp_seq == override_seq) ? OV_AT : at_of(rsp_seq);
          rsp_seq++;
          pending = 1'b0;
        end else if (spurious_en && (bus.req_valid || bus.cell_valid)) begin
          bus.rsp_valid  = 1'b1;
          bus.rsp_bitmap = 16'hDEAD;
          bus.rsp_attr   = 25'h0BADBAD;
        end
        if (bus.req_valid && bus.req_ready && !drop_rsp) pending = 1'b1;
      end
    end
  end

  // Request monitor.
  initial forever begin
    req_t e;
    @(negedge clk); #1;
    if (rst_n && bus.req_valid && bus.req_ready) begin
      if (req_q.size() == 0) check("req_unexpected", 64'd1, 64'd0);
      else begin
        e = req_q.pop_front();
        check("req_col", 64'(bus.req_col), 64'(e.col));
        check("req_row", 64'(bus.req_row), 64'(e.row));
      end
    end
  end

  // Cell monitor.
  initial forever begin
    cell_t e;
    @(negedge clk); #1;
    if (rst_n && bus.cell_valid && bus.cell_ready) begin
      cells_seen++;
      if (cell_q.size() == 0) check("cell_unexpected", 64'd1, 64'd0);
      else begin
        e = cell_q.pop_front();
        check("cell_scanline", 64'(bus.sty_scanline), 64'(e.scan));
        check("cell_bitmap",   64'(bus.sty_bitmap),   64'(e.bm));
        check("cell_attr",     64'(bus.sty_attr),     64'(e.at));
        check("cell_cursor",   64'(bus.cursor_hit),   64'(e.hit));
      end
    end
  end

  // Frame-end monitor.
  initial forever begin
    frame_t e;
    @(negedge clk); #1;
    if (rst_n && frame_done) begin
      frames_seen++;
      if (frame_q.size() == 0) check("frame_unexpected", 64'd1, 64'd0);
      else begin
        e = frame_q.pop_front();
        check("frame_faint", 64'(faint_phase), 64'(e.faint));
        check("frame_blink", 64'(blink_phase), 64'(e.blink));
        check("frame_busy",  64'(busy),        64'(e.busy));
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("start_req_latency", 64'(bus.req_valid), 64'd1);
    check("start_busy", 64'(busy), 64'd1);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_seen < target && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    check("frames_reached", 64'(frames_seen), 64'(target));
  endtask

  initial begin
    int fs;
    int cs;
    int cyc;
    int n;
    int low;

    bus.cell_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", all_outputs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame with cursor at (1,0): order, scanlines, latency, end state.
    push_frame(1'b1, 1'b0, 1'b0);
    fs = frames_seen;
    cs = cells_seen;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("t1_req_latency", 64'(bus.req_valid), 64'd1);
    cyc = 1;
    // Start edge plus 8 cells of FETCH/WAIT/PRESENT, 3 cycles each.
    while (!frame_done && cyc < 200) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("t1_frame_cycles", 64'(cyc), 64'd25);
    @(negedge clk); #2;
    check("t1_busy_after", 64'(busy), 64'd0);
    check("t1_frames", 64'(frames_seen - fs), 64'd1);
    check("t1_cells", 64'(cells_seen - cs), 64'd8);
    check("t1_req_drained", 64'(req_q.size()), 64'd0);

    // Backpressure on the first cell.
    bus.cell_ready = 1'b0;
    override_seq = model_seq;
    push_frame(1'b0, 1'b1, 1'b0);
    fs = frames_seen;
    pulse_start();
    n = 0;
    while (!bus.cell_valid && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("t2_cell_valid_seen", 64'(bus.cell_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid",  64'(bus.cell_valid),   64'd1);
      check("t2_hold_bitmap", 64'(bus.sty_bitmap),   64'h0A5C3);
      check("t2_hold_attr",   64'(bus.sty_attr),     64'h1ABCDEF);
      check("t2_hold_scan",   64'(bus.sty_scanline), 64'd0);
      check("t2_no_req",      64'(bus.req_valid),    64'd0);
      @(negedge clk); #1;
    end
    @(negedge clk);
    bus.cell_ready = 1'b1;
    wait_frames(fs + 1, 200);
    @(negedge clk); #2;
    check("t2_busy_after", 64'(busy), 64'd0);

    // Stray start mid-frame, stray rsp_valid in FETCH/PRESENT, stuttering ready.
    spurious_en = 1'b1;
    ready_toggle = 1'b1;
    push_frame(1'b1, 1'b1, 1'b0);
    fs = frames_seen;
    cs = cells_seen;
    pulse_start();
    repeat (7) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_frames(fs + 1, 300);
    spurious_en = 1'b0;
    ready_toggle = 1'b0;
    @(negedge clk); #2;
    check("t6_busy_after", 64'(busy), 64'd0);
    check("t6_cells", 64'(cells_seen - cs), 64'd8);

    // Reset while waiting for the first response.
    drop_rsp = 1'b1;
    begin
      req_t rq;
      rq.col = 7'd0;
      rq.row = 5'd0;
      req_q.push_back(rq);
    end
    pulse_start();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("t4_reset_outputs", all_outputs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drop_rsp = 1'b0;
    override_seq = -1;
    model_seq = 0;
    check("t4_req_drained", 64'(req_q.size()), 64'd0);

    // Four chained frames from fresh phases: faint 1,0,1,0 and blink 0,1,1,0.
    continuous = 1'b1;
    push_frame(1'b1, 1'b0, 1'b1);
    push_frame(1'b0, 1'b1, 1'b1);
    push_frame(1'b1, 1'b1, 1'b1);
    push_frame(1'b0, 1'b0, 1'b0);
    fs = frames_seen;
    cs = cells_seen;
    pulse_start();
    n = 0;
    low = 0;
    while (frames_seen < fs + 4 && n < 600) begin
      @(negedge clk);
      if (frames_seen >= fs + 3) continuous = 1'b0;
      #2;
      n++;
      if (!busy && frames_seen < fs + 4) low++;
    end
    check("t3_frames", 64'(frames_seen), 64'(fs + 4));
    check("t3_busy_gaps", 64'(low), 64'd0);
    @(negedge clk); #2;
    check("t3_busy_after", 64'(busy), 64'd0);
    check("t3_cells", 64'(cells_seen - cs), 64'd32);

    repeat (4) @(negedge clk);
    #2;
    check("end_req_q",   64'(req_q.size()),   64'd0);
    check("end_cell_q",  64'(cell_q.size()),  64'd0);
    check("end_frame_q", 64'(frame_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
